// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the ROM address combinationally
// and fills the IF/ID register, with stall, flush and redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall_F,
  input  logic        Flush_D,
  input  logic        Redirect_En,
  input  logic [31:0] Redirect_Target,
  output logic [31:0] IMem_Addr,
  input  logic [31:0] IMem_Instr,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D,
  output logic        Redirect_Pending,
  output logic [31:0] Fetch_Count
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;
  logic        redir_taken_s;

  assign target_s   = {Redirect_Target[31:2], 2'b00};
  assign pc_plus4_s = pc_q + 32'd4;

  // Next PC, redirect FSM and IF/ID contents.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    instr_d       = instr_q;
    pcd_d         = pcd_q;
    pcp4_d        = pcp4_q;
    valid_d       = valid_q;
    cnt_d         = cnt_q;
    redir_taken_s = 1'b0;

    case (state_q)
      RUN, HOLD: begin
        if (!Stall_F && Redirect_En) begin
          pc_d          = target_s;
          pend_d        = 32'h0000_0000;
          state_d       = RUN;
          redir_taken_s = 1'b1;
        end else if (!Stall_F && (state_q == HOLD)) begin
          pc_d          = pend_q;
          pend_d        = 32'h0000_0000;
          state_d       = RUN;
          redir_taken_s = 1'b1;
        end else if (Stall_F && Redirect_En) begin
          pend_d  = target_s;
          state_d = HOLD;
        end else if (Stall_F) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_plus4_s;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // A flush wins even over a stall; a taken redirect makes this cycle's word wrong-path.
    if (Flush_D || (!Stall_F && redir_taken_s)) begin
      instr_d = 32'h0000_0000;
      pcd_d   = 32'h0000_0000;
      pcp4_d  = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (Stall_F) begin
      valid_d = valid_q;
    end else begin
      instr_d = IMem_Instr;
      pcd_d   = pc_q;
      pcp4_d  = pc_plus4_s;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0000_0000;
      instr_q <= 32'h0000_0000;
      pcd_q   <= 32'h0000_0000;
      pcp4_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      cnt_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IMem_Addr        = pc_q;
  assign Instr_D          = instr_q;
  assign PC_D             = pcd_q;
  assign PCPlus4_D        = pcp4_q;
  assign Valid_D          = valid_q;
  assign Fetch_Count      = cnt_q;
  assign Redirect_Pending = (state_q == HOLD);

endmodule
